// File: rtl/bw_mult_pkg.sv
// Shared types and helpers for the sequential Baugh-Wooley multiplier (bw_mult_seq).
package bw_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BW_MAXW = 128;

    // Correction word: ones at column n and column 2n-1; callers slice the low 2n bits.
    function automatic logic [BW_MAXW-1:0] bw_const(input int unsigned n);
        logic [BW_MAXW-1:0] c;
        c = (BW_MAXW'(1'b1) << n) | (BW_MAXW'(1'b1) << (2 * n - 1));
        return c;
    endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One Baugh-Wooley partial-product row, shifted into place; row 0 also carries the
// correction constant. Low columns are zeroed when APPROX_TRUNC_EN is defined.
module bw_pp_row
    import bw_mult_pkg::*;
#(
    parameter int N     = 8,
    parameter int TRUNC = 2,
    parameter int JW    = 4
) (
    input  logic [N-1:0]   a,
    input  logic           b_bit,
    input  logic [JW-1:0]  j,
    input  logic           sgn,
    output logic [2*N-1:0] row
);

    localparam logic [BW_MAXW-1:0] BWC_FULL = bw_const(N);
    localparam logic [2*N-1:0]     BWC      = BWC_FULL[2*N-1:0];
`ifdef APPROX_TRUNC_EN
    localparam logic [2*N-1:0]     KEEP     = {2*N{1'b1}} << TRUNC;
`else
    // Exact build: every column kept whatever TRUNC is set to.
    localparam logic [2*N-1:0]     KEEP     = {2*N{1'b1}} | ({2*N{1'b1}} << TRUNC);
`endif

    logic [N-1:0]   bits_s;
    logic [2*N-1:0] shifted_s;

    // AND array bits; signed mode inverts the bits where exactly one index is the sign position.
    always_comb begin
        bits_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            bits_s[i] = (a[i] & b_bit) ^ (sgn & ((i == N - 1) ^ (j == JW'(N - 1))));
        end
    end

    assign shifted_s = {{N{1'b0}}, bits_s} << j;
    assign row       = (shifted_s & KEEP) |
                       ((sgn && (j == {JW{1'b0}})) ? BWC : {2*N{1'b0}});

endmodule

// File: rtl/bw_mult_seq.sv
// Sequential N-bit Baugh-Wooley multiplier, one partial-product row per clock, with
// valid/ready handshakes. Define APPROX_TRUNC_EN for the truncated approximate variant.
module bw_mult_seq
    import bw_mult_pkg::*;
#(
    parameter int N     = 8,
    parameter int TRUNC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] y,
    output logic           busy
);

    localparam int JW = $clog2(N + 1);

    state_t         state_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_sh_r;
    logic           sgn_r;
    logic [2*N-1:0] acc_r;
    logic [2*N-1:0] y_r;
    logic [JW-1:0]  j_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;
    logic [2*N-1:0] row_s;

    bw_pp_row #(
        .N     (N),
        .TRUNC (TRUNC),
        .JW    (JW)
    ) u_row (
        .a     (a_r),
        .b_bit (b_sh_r[0]),
        .j     (j_r),
        .sgn   (sgn_r),
        .row   (row_s)
    );

    // Control FSM and datapath; rows 0..N-1 are added, then one more cycle publishes y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {N{1'b0}};
            b_sh_r      <= {N{1'b0}};
            sgn_r       <= 1'b0;
            acc_r       <= {2*N{1'b0}};
            y_r         <= {2*N{1'b0}};
            j_r         <= {JW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_sh_r     <= b;
                        sgn_r      <= sgn;
                        acc_r      <= {2*N{1'b0}};
                        j_r        <= {JW{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (j_r == JW'(N)) begin
                        y_r         <= acc_r;
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        // Carries past bit 2N-1 drop out: modulo-2^(2N) arithmetic.
                        acc_r  <= acc_r + row_s;
                        j_r    <= j_r + JW'(1'b1);
                        b_sh_r <= {1'b0, b_sh_r[N-1:1]};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bw_mult_seq.sv
// Self-checking bench for bw_mult_seq: an N=3 instance (TRUNC=2) and an N=8 instance (TRUNC=0).
module tb_bw_mult_seq;

    localparam int TR3 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       v3 = 1'b0, s3 = 1'b0, or3 = 1'b1;
    logic [2:0] a3 = 3'd0, b3 = 3'd0;
    logic       rdy3, ov3, busy3;
    logic [5:0] y3;

    logic       v8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       rdy8, ov8, busy8;
    logic [15:0] y8;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    logic [5:0]  exp3[$];
    int          t3[$];
    logic [15:0] exp8[$];
    int          t8[$];

    bw_mult_seq #(.N(3), .TRUNC(TR3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .a(a3), .b(b3), .sgn(s3),
        .out_valid(ov3), .out_ready(or3), .y(y3), .busy(busy3)
    );

    bw_mult_seq #(.N(8), .TRUNC(0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .sgn(s8),
        .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: true product mod 2^(2n); truncation removes the low-column array bits.
    function automatic logic [15:0] model(input int n, input int tr, input logic [7:0] a,
                                          input logic [7:0] b, input logic s);
        longint av, bv, p, m;
        m  = (longint'(1) << (2 * n)) - 1;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[n-1]) av = av - (longint'(1) << n);
        if (s && b[n-1]) bv = bv - (longint'(1) << n);
        p = av * bv;
`ifdef APPROX_TRUNC_EN
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                if (i + j < tr) begin
                    logic bt;
                    bt = (a[i] & b[j]) ^ (s && ((i == n - 1) != (j == n - 1)));
                    if (bt) p = p - (longint'(1) << (i + j));
                end
            end
        end
`else
        if (tr < 0) p = 0;
`endif
        return 16'(p & m);
    endfunction

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        while (!rdy3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy3) begin
            check("run3_timeout", 64'(rdy3), 64'd1);
            return;
        end
        a3 = a; b3 = b; s3 = s; v3 = 1'b1;
        exp3.push_back(6'(model(3, TR3, {5'd0, a}, {5'd0, b}, s)));
        t3.push_back(cyc + 1);
        @(negedge clk);
        v3 = 1'b0;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n = 0;
        @(negedge clk);
        while (!rdy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy8) begin
            check("run8_timeout", 64'(rdy8), 64'd1);
            return;
        end
        a8 = a; b8 = b; s8 = s; v8 = 1'b1;
        exp8.push_back(model(8, 0, a, b, s));
        t8.push_back(cyc + 1);
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic wait3();
        int n = 0;
        while (!ov3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ov3) check("wait3_timeout", 64'(ov3), 64'd1);
    endtask

    task automatic wait8();
        int n = 0;
        while (!ov8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ov8) check("wait8_timeout", 64'(ov8), 64'd1);
    endtask

    // Compare process: every new result against the model, plus hold/latency/ready rules.
    logic        ov3_q = 1'b0, ov8_q = 1'b0;
    logic [5:0]  hold3 = 6'd0;
    logic [15:0] hold8 = 16'd0;
    always @(negedge clk) begin
        if (rst) begin
            ov3_q = 1'b0;
            ov8_q = 1'b0;
        end else begin
            if (ov3) begin
                if (!ov3_q) begin
                    if (exp3.size() == 0) begin
                        check("spurious3", 64'(y3), 64'(hold3) ^ 64'd1);
                    end else begin
                        check("y3", 64'(y3), 64'(exp3.pop_front()));
                        check("lat3", 64'(cyc - t3.pop_front()), 64'd4);
                    end
                    hold3 = y3;
                end else begin
                    check("hold3", 64'(y3), 64'(hold3));
                end
                check("rdy3_done", 64'(rdy3), 64'd0);
            end
            if (ov8) begin
                if (!ov8_q) begin
                    if (exp8.size() == 0) begin
                        check("spurious8", 64'(y8), 64'(hold8) ^ 64'd1);
                    end else begin
                        check("y8", 64'(y8), 64'(exp8.pop_front()));
                        check("lat8", 64'(cyc - t8.pop_front()), 64'd9);
                    end
                    hold8 = y8;
                end else begin
                    check("hold8", 64'(y8), 64'(hold8));
                end
                check("rdy8_done", 64'(rdy8), 64'd0);
            end
            ov3_q = ov3;
            ov8_q = ov8;
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_rdy3", 64'(rdy3), 64'd1);
        check("rst_ov3", 64'(ov3), 64'd0);
        check("rst_y3", 64'(y3), 64'd0);
        check("rst_busy3", 64'(busy3), 64'd0);
        check("rst_rdy8", 64'(rdy8), 64'd1);
        check("rst_y8", 64'(y8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Pin the model with hand-computed values.
        check("pin_m4m4", 64'(model(3, TR3, 8'd4, 8'd4, 1'b1)), 64'd16);
        check("pin_3m4", 64'(model(3, TR3, 8'd3, 8'd4, 1'b1)), 64'h34);
        check("pin_80x80", 64'(model(8, 0, 8'h80, 8'h80, 1'b1)), 64'h4000);
        check("pin_ffx01", 64'(model(8, 0, 8'hFF, 8'h01, 1'b1)), 64'hFFFF);
`ifdef APPROX_TRUNC_EN
        check("pin_7x7u", 64'(model(3, TR3, 8'd7, 8'd7, 1'b0)), 64'd44);
        check("pin_3x3t", 64'(model(3, TR3, 8'd3, 8'd3, 1'b0)), 64'd4);
`else
        check("pin_7x7u", 64'(model(3, TR3, 8'd7, 8'd7, 1'b0)), 64'd49);
        check("pin_3x3t", 64'(model(3, TR3, 8'd3, 8'd3, 1'b0)), 64'd9);
`endif

        // Directed N=3 vectors against literals.
        run3(3'b100, 3'b100, 1'b1); wait3(); check("d3_m4m4", 64'(y3), 64'b010000);
        run3(3'b011, 3'b100, 1'b1); wait3(); check("d3_3m4", 64'(y3), 64'b110100);
        run3(3'b000, 3'b101, 1'b0); wait3(); check("d3_0x5u", 64'(y3), 64'd0);
`ifdef APPROX_TRUNC_EN
        run3(3'b111, 3'b111, 1'b0); wait3(); check("d3_7x7u", 64'(y3), 64'd44);
        run3(3'b011, 3'b011, 1'b0); wait3(); check("d3_3x3t", 64'(y3), 64'b000100);
`else
        run3(3'b111, 3'b111, 1'b0); wait3(); check("d3_7x7u", 64'(y3), 64'b110001);
        run3(3'b011, 3'b011, 1'b0); wait3(); check("d3_3x3t", 64'(y3), 64'd9);
`endif

        // Exhaustive signed N=3.
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                run3(3'(ai), 3'(bi), 1'b1);
            end
        end

        // Directed N=8 vectors.
        run8(8'h80, 8'h80, 1'b1); wait8(); check("d8_80x80", 64'(y8), 64'h4000);
        run8(8'hFF, 8'h01, 1'b1); wait8(); check("d8_ffx01", 64'(y8), 64'hFFFF);
        run8(8'h03, 8'h03, 1'b0); wait8(); check("d8_3x3", 64'(y8), 64'd9);
        run8(8'hFF, 8'hFF, 1'b0); wait8(); check("d8_ffxffu", 64'(y8), 64'hFE01);

        // Random N=8 pairs, both modes.
        repeat (2000) run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        // Back-pressure on the N=3 instance.
        or3 = 1'b0;
        run3(3'b011, 3'b101, 1'b1);
        wait3();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_ov3", 64'(ov3), 64'd1);
            v3 = k[0];
            a3 = 3'($urandom);
            b3 = 3'($urandom);
        end
        v3 = 1'b0;
        or3 = 1'b1;
        @(negedge clk);
        check("bp_ov3_fall", 64'(ov3), 64'd0);
        check("bp_rdy3_rise", 64'(rdy3), 64'd1);
        run3(3'b010, 3'b011, 1'b0); wait3(); check("bp_after", 64'(y3), 64'd6);

        // Reset two cycles into BUSY aborts the transaction.
        run8(8'h11, 8'h22, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy8", 64'(busy8), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_ov8", 64'(ov8), 64'd0);
        check("mid_y8", 64'(y8), 64'd0);
        check("mid_rdy8", 64'(rdy8), 64'd1);
        check("mid_busy8_clr", 64'(busy8), 64'd0);
        exp8.delete(); t8.delete(); exp3.delete(); t3.delete();
        @(negedge clk);
        rst = 1'b0;
        run8(8'h7B, 8'h2D, 1'b0); wait8(); check("post_rst_u", 64'(y8), 64'h159F);
        run8(8'hFD, 8'h05, 1'b1); wait8(); check("post_rst_s", 64'(y8), 64'hFFF1);

        repeat (20) @(negedge clk);
        check("drain3", 64'(exp3.size()), 64'd0);
        check("drain8", 64'(exp8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
